// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the write port of advanced_sync_fifo.
// One producer at a time owns the port for a burst bounded by its last
// marker, BURST_MAX accepted beats, or STALL_TIMEOUT idle cycles.
// Beats pass straight through to the FIFO in the same cycle they are accepted.
module fifo_wr_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int BURST_MAX     = 8,
  parameter int STALL_TIMEOUT = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            fifo_full,
  input  logic                            fifo_almost_full,
  output logic                            fifo_wr_en,
  output logic [DATA_WIDTH-1:0]           fifo_data_in,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic                            busy
);

  localparam int ID_W    = $clog2(NUM_REQ);
  localparam int BEAT_W  = $clog2(BURST_MAX + 1);
  localparam int STALL_W = $clog2(STALL_TIMEOUT + 1);

  localparam logic [ID_W-1:0]    LAST_RST    = ID_W'(NUM_REQ - 1);
  localparam logic [ID_W:0]      NUM_REQ_W   = (ID_W + 1)'(NUM_REQ);
  localparam logic [BEAT_W-1:0]  BEAT_LIMIT  = BEAT_W'(BURST_MAX);
  localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(STALL_TIMEOUT - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ID_W-1:0]     owner;
  logic [ID_W-1:0]     last_owner;
  logic [ID_W-1:0]     pick;
  logic                pick_ok;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [STALL_W-1:0]  stall_cnt;

  logic                own_valid;
  logic                own_last;
  logic                accept;
  logic                burst_done;
  logic                stall_done;
  logic                start_grant;

  logic [DATA_WIDTH-1:0] slot [NUM_REQ];

  // Unpack the flat producer data bus into one word per producer
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
    assign slot[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Owner handshake terms shared by the FSM, the counters and the datapath
  assign own_valid   = req_valid[owner];
  assign own_last    = req_last[owner];
  assign accept      = (state == GRANT) && own_valid && !fifo_full;
  assign burst_done  = accept && (own_last || ((beat_cnt + BEAT_W'(1)) == BEAT_LIMIT));
  assign stall_done  = (state == GRANT) && !own_valid && (stall_cnt == STALL_LIMIT);
  assign start_grant = (state == IDLE) && pick_ok && !fifo_almost_full;

  // Round-robin scan starting just after the previous owner
  // NOTE: every variable driven here gets a default first, so no latch is inferred.
  always_comb begin
    logic [ID_W:0] cand;
    pick    = '0;
    pick_ok = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_owner} + (ID_W + 1)'(k);
      if (cand >= NUM_REQ_W) begin
        cand = cand - NUM_REQ_W;
      end
      if (!pick_ok && req_valid[cand[ID_W-1:0]]) begin
        pick    = cand[ID_W-1:0];
        pick_ok = 1'b1;
      end
    end
  end

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decision: one IDLE cycle between grants, release on burst end or stall timeout
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_grant) state_nxt = GRANT;
      GRANT:   if (burst_done || stall_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Owner, round-robin pointer and burst/stall counters
  always_ff @(posedge clk) begin
    if (rst) begin
      owner      <= '0;
      last_owner <= LAST_RST;
      beat_cnt   <= '0;
      stall_cnt  <= '0;
    end else if (start_grant) begin
      owner     <= pick;
      beat_cnt  <= '0;
      stall_cnt <= '0;
    end else if (state == GRANT) begin
      // A stalled beat under fifo_full with valid high leaves both counters alone
      if (accept) begin
        beat_cnt  <= beat_cnt + BEAT_W'(1);
        stall_cnt <= '0;
      end else if (!own_valid) begin
        stall_cnt <= stall_cnt + STALL_W'(1);
      end
      if (burst_done || stall_done) begin
        last_owner <= owner;
      end
    end
  end

  // Outputs: zero-latency pass-through of the owner's stream, silenced during reset
  always_comb begin
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_data_in = '0;
    if ((state == GRANT) && !rst) begin
      req_ready[owner] = !fifo_full;
      fifo_wr_en       = accept;
      if (accept) begin
        fifo_data_in = slot[owner];
      end
    end
  end

  assign busy     = (state == GRANT);
  assign grant_id = owner;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios followed by a
// randomized phase, all compared cycle by cycle against a behavioural model
// built from producer beat queues and the arbitration rules.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ       = 4;
  localparam int DATA_WIDTH    = 32;
  localparam int BURST_MAX     = 8;
  localparam int STALL_TIMEOUT = 16;

  logic                          clk;
  logic                          rst;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_almost_full;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_data_in;
  logic [1:0]                    grant_id;
  logic                          busy;

  fifo_wr_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .DATA_WIDTH   (DATA_WIDTH),
    .BURST_MAX    (BURST_MAX),
    .STALL_TIMEOUT(STALL_TIMEOUT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_last        (req_last),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .fifo_full       (fifo_full),
    .fifo_almost_full(fifo_almost_full),
    .fifo_wr_en      (fifo_wr_en),
    .fifo_data_in    (fifo_data_in),
    .grant_id        (grant_id),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } beat_t;

  // Producer side: pending beats per producer and a per-cycle willingness mask
  beat_t      q [NUM_REQ][$];
  logic [3:0] en;
  logic       rst_c;
  logic       full_c;
  logic       af_c;

  // Behavioural arbiter model
  bit m_busy;
  int m_owner;
  int m_last;
  int m_beats;
  int m_stalls;

  // Observations taken from the DUT at each sample point
  int          grant_log[$];
  int          grant_cyc[$];
  int          wpg[$];
  logic [31:0] wlog[$];
  logic        prev_busy;
  logic        obs_busy;
  logic        obs_wr;
  logic [1:0]  obs_gid;
  logic [3:0]  obs_ready;
  int          cyc;

  int total;
  int bad;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int qget(input int qq[$], input int k);
    return (k < qq.size()) ? qq[k] : -1;
  endfunction

  function automatic logic [31:0] wget(input int k);
    return (k < wlog.size()) ? wlog[k] : 32'hdead_beef;
  endfunction

  function automatic bit all_empty();
    bit e;
    e = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) if (q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic push_burst(input int i, input int n, input bit with_last, input logic [31:0] base);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.d = base + 32'(k);
      b.l = with_last && (k == n - 1);
      q[i].push_back(b);
    end
  endtask

  task automatic clear_queues();
    for (int i = 0; i < NUM_REQ; i++) q[i].delete();
  endtask

  task automatic clear_logs();
    grant_log.delete();
    grant_cyc.delete();
    wpg.delete();
    wlog.delete();
  endtask

  // Present each willing producer's head beat; idle producers show junk data
  task automatic drive_inputs();
    rst              = rst_c;
    fifo_full        = full_c;
    fifo_almost_full = af_c;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (en[i] && q[i].size() != 0) begin
        req_valid[i]              = 1'b1;
        req_last[i]               = q[i][0].l;
        req_data[i*32 +: 32]      = q[i][0].d;
      end else begin
        req_valid[i]              = 1'b0;
        req_last[i]               = 1'($urandom_range(0, 1));
        req_data[i*32 +: 32]      = $urandom;
      end
    end
  endtask

  // One clock cycle: drive at negedge, compare shortly after, advance model at posedge
  task automatic step();
    logic [3:0]  e_ready;
    logic        e_wr;
    logic [31:0] e_data;
    cyc++;
    @(negedge clk);
    drive_inputs();
    #1;
    e_ready = '0;
    e_wr    = 1'b0;
    e_data  = '0;
    if (!rst_c && m_busy) begin
      e_ready[m_owner] = !full_c;
      e_wr             = req_valid[m_owner] && !full_c;
      if (e_wr) e_data = req_data[m_owner*32 +: 32];
    end
    check("busy", busy, m_busy);
    if (m_busy) check("grant_id", grant_id, m_owner);
    check("req_ready", req_ready, e_ready);
    check("fifo_wr_en", fifo_wr_en, e_wr);
    check("fifo_data_in", fifo_data_in, e_data);

    obs_busy  = busy;
    obs_wr    = fifo_wr_en;
    obs_gid   = grant_id;
    obs_ready = req_ready;
    if (busy && !prev_busy) begin
      grant_log.push_back(int'(grant_id));
      grant_cyc.push_back(cyc);
      wpg.push_back(0);
    end
    prev_busy = busy;
    if (fifo_wr_en) begin
      wlog.push_back(fifo_data_in);
      if (wpg.size() != 0) wpg[wpg.size()-1] = wpg[wpg.size()-1] + 1;
    end

    // Producers retire a beat on an expected handshake
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && e_ready[i]) void'(q[i].pop_front());
    end

    // Arbitration rules applied to this cycle's inputs
    if (rst_c) begin
      m_busy   = 1'b0;
      m_owner  = 0;
      m_last   = NUM_REQ - 1;
      m_beats  = 0;
      m_stalls = 0;
    end else if (!m_busy) begin
      if (req_valid != 0 && !af_c) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          if (req_valid[(m_last + k) % NUM_REQ]) begin
            m_owner = (m_last + k) % NUM_REQ;
            break;
          end
        end
        m_busy   = 1'b1;
        m_beats  = 0;
        m_stalls = 0;
      end
    end else if (e_wr) begin
      m_beats++;
      m_stalls = 0;
      if (req_last[m_owner] || m_beats == BURST_MAX) begin
        m_busy = 1'b0;
        m_last = m_owner;
      end
    end else if (!req_valid[m_owner]) begin
      if (m_stalls == STALL_TIMEOUT - 1) begin
        m_busy = 1'b0;
        m_last = m_owner;
      end else begin
        m_stalls++;
      end
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    rst_c = 1'b1;
    step();
    rst_c = 1'b0;
    clear_queues();
  endtask

  initial begin
    int t0;
    int cnt0;
    int exp2[5];
    total = 0; bad = 0; cyc = 0;
    en = '0; rst_c = 1'b1; full_c = 1'b0; af_c = 1'b0;
    rst = 1'b1; fifo_full = 1'b0; fifo_almost_full = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0;
    prev_busy = 1'b0;
    m_busy = 1'b0; m_owner = 0; m_last = NUM_REQ - 1; m_beats = 0; m_stalls = 0;

    // Reset state
    do_reset();
    do_reset();
    step();
    check("rst_busy", obs_busy, 0);
    check("rst_gid", obs_gid, 0);
    check("rst_wr", obs_wr, 0);
    check("rst_ready", obs_ready, 0);

    // 1: lone producer 1, five beats A0..A4
    clear_logs();
    push_burst(1, 5, 1'b1, 32'hA0);
    en = 4'b0010;
    t0 = cyc;
    for (int c = 0; c < 10; c++) step();
    check("t1_ngrant", grant_log.size(), 1);
    check("t1_gid", qget(grant_log, 0), 1);
    check("t1_latency", qget(grant_cyc, 0), t0 + 2);
    check("t1_nwrites", wlog.size(), 5);
    for (int k = 0; k < 5; k++) check("t1_data", wget(k), 32'hA0 + 32'(k));

    // 2: four producers with back-to-back 3-beat bursts
    do_reset();
    clear_logs();
    for (int i = 0; i < NUM_REQ; i++) begin
      push_burst(i, 3, 1'b1, 32'h1000 * i);
      push_burst(i, 3, 1'b1, 32'h1000 * i + 32'h10);
    end
    en = 4'b1111;
    for (int c = 0; c < 200 && !all_empty(); c++) step();
    check("t2_drained", all_empty(), 1);
    for (int c = 0; c < 3; c++) step();
    exp2 = '{0, 1, 2, 3, 0};
    check("t2_ngrant", grant_log.size(), 8);
    for (int k = 0; k < 5; k++) check("t2_order", qget(grant_log, k), exp2[k]);
    for (int k = 0; k < 8; k++) check("t2_burst", qget(wpg, k), 3);
    check("t2_round", qget(grant_cyc, 4) - qget(grant_cyc, 0), 16);

    // 3: producer 2 never marks last; BURST_MAX caps the grant
    clear_logs();
    push_burst(2, 10, 1'b0, 32'h3000);
    en = 4'b0100;
    for (int c = 0; c < 40; c++) step();
    check("t3_gids", {qget(grant_log, 0), qget(grant_log, 1)}, {32'd2, 32'd2});
    check("t3_cap", qget(wpg, 0), BURST_MAX);
    check("t3_rest", qget(wpg, 1), 2);
    check("t3_regrant", qget(grant_cyc, 1) - qget(grant_cyc, 0), BURST_MAX + 1);

    // 4: producer 0 goes quiet after two beats; producer 3 waits
    clear_logs();
    push_burst(0, 2, 1'b0, 32'h4000);
    push_burst(3, 2, 1'b1, 32'h4300);
    en = 4'b0001;
    step();
    step();
    en = 4'b1001;
    cnt0 = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (obs_busy && obs_gid == 2'd0) cnt0++;
    end
    check("t4_order", {qget(grant_log, 0), qget(grant_log, 1)}, {32'd0, 32'd3});
    check("t4_hold", cnt0 + 1, 2 + STALL_TIMEOUT);
    check("t4_gap", qget(grant_cyc, 1) - qget(grant_cyc, 0), 2 + STALL_TIMEOUT + 1);
    check("t4_writes", {qget(wpg, 0), qget(wpg, 1)}, {32'd2, 32'd2});

    // 5: almost_full blocks new grants; full stalls a running burst
    clear_logs();
    af_c = 1'b1;
    push_burst(1, 10, 1'b0, 32'h5000);
    en = 4'b0010;
    for (int c = 0; c < 5; c++) step();
    check("t5_af_block", grant_log.size(), 0);
    af_c = 1'b0;
    for (int c = 0; c < 10 && wlog.size() < 2; c++) begin
      step();
      if (obs_busy) af_c = 1'b1;
    end
    check("t5_two", wlog.size(), 2);
    full_c = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check("t5_full_wr", obs_wr, 0);
      check("t5_full_ready", obs_ready, 0);
    end
    full_c = 1'b0;
    for (int c = 0; c < 12; c++) step();
    check("t5_cap", qget(wpg, 0), BURST_MAX);
    for (int k = 0; k < BURST_MAX; k++) check("t5_data", wget(k), 32'h5000 + 32'(k));
    af_c = 1'b0;
    for (int c = 0; c < 25; c++) step();
    check("t5_total", wlog.size(), 10);
    check("t5_tail", {wget(8), wget(9)}, {32'h5008, 32'h5009});

    // 6: reset in the middle of a burst's third beat
    clear_logs();
    for (int i = 0; i < NUM_REQ; i++) push_burst(i, 4, 1'b1, 32'h6000 + 32'h100 * i);
    en = 4'b1111;
    for (int c = 0; c < 20 && wlog.size() < 2; c++) step();
    check("t6_two", wlog.size(), 2);
    rst_c = 1'b1;
    step();
    check("t6_rstcyc_wr", obs_wr, 0);
    rst_c = 1'b0;
    clear_queues();
    clear_logs();
    for (int i = 0; i < NUM_REQ; i++) push_burst(i, 4, 1'b1, 32'h6800 + 32'h100 * i);
    step();
    check("t6_busy", obs_busy, 0);
    check("t6_wr", obs_wr, 0);
    check("t6_gid", obs_gid, 0);
    for (int c = 0; c < 10; c++) step();
    check("t6_first", qget(grant_log, 0), 0);
    check("t6_first_data", wget(0), 32'h6800);

    // 7: random traffic, backpressure and occasional reset
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (q[i].size() == 0 && $urandom_range(0, 3) == 0)
          push_burst(i, $urandom_range(1, 10), $urandom_range(0, 3) != 0, $urandom);
        en[i] = ($urandom_range(0, 4) != 0);
      end
      full_c = ($urandom_range(0, 5) == 0);
      af_c   = ($urandom_range(0, 3) == 0);
      rst_c  = ($urandom_range(0, 149) == 0);
      step();
    end
    rst_c = 1'b0; full_c = 1'b0; af_c = 1'b0; en = 4'b1111;
    for (int c = 0; c < 300 && !(all_empty() && !obs_busy); c++) step();
    check("t7_drained", all_empty() && !obs_busy, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
